// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Latency: accept at T, result captured at T+1, response valid from T+2; responses are held until the owner takes them, and requests are accepted only in IDLE.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sel,
    input  logic [OPW-1:0]   req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sel,
    input  logic [OPW-1:0]   req1_op,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sel,
    output logic [OPW-1:0]   alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_sign,

    output logic             rsp0_valid,
    output logic             rsp1_valid,
    input  logic             rsp0_ready,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_sign
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sel_q, sel_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             sign_q, sign_d;

    logic             gnt0;
    logic             gnt1;
    logic             owner_rdy;

    // Ready is gated by reset so nothing can be accepted while rst is low.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && (state_q == ST_IDLE)) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = !last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign owner_rdy = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        op_d         = op_q;
        res_d        = res_q;
        carry_d      = carry_q;
        zero_d       = zero_q;
        sign_d       = sign_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d      = gnt1;
                    last_grant_d = gnt1;
                    a_d          = gnt1 ? req1_a   : req0_a;
                    b_d          = gnt1 ? req1_b   : req0_b;
                    sel_d        = gnt1 ? req1_sel : req0_sel;
                    op_d         = gnt1 ? req1_op  : req0_op;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The ALU leaves a stale carry on non-ADD ops, so mask it here.
                res_d   = alu_result;
                zero_d  = alu_zero;
                sign_d  = alu_sign;
                carry_d = (op_q == OP_ADD) ? alu_carry : 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (owner_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= 1'b0;
            op_q         <= '0;
            res_q        <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            sign_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            op_q         <= op_d;
            res_q        <= res_d;
            carry_q      <= carry_d;
            zero_q       <= zero_d;
            sign_q       <= sign_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign alu_sel = sel_q;
    assign alu_op  = op_q;

    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) &&  owner_q;
    assign rsp_result = res_q;
    assign rsp_carry  = carry_q;
    assign rsp_zero   = zero_q;
    assign rsp_sign   = sign_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the alu_* ports plus a response scoreboard.
module tb_alu_arbiter;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_SHL = 5'b01010;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sel;
    logic [31:0] req0_a, req0_b;
    logic [4:0]  req0_op;
    logic        req1_valid, req1_ready, req1_sel;
    logic [31:0] req1_a, req1_b;
    logic [4:0]  req1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        alu_sel, alu_carry, alu_zero, alu_sign;
    logic [4:0]  alu_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_carry, rsp_zero, rsp_sign;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .OPW(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_op(alu_op),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign)
    );

    // The ALU drives carry=1 on non-ADD ops to mimic a stale held carry.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b1;
        case (alu_op)
            OP_ADD:  {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            OP_AND:  alu_result = alu_a & alu_b;
            OP_SHL:  alu_result = alu_a << alu_b[4:0];
            default: alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == 32'd0);
    assign alu_sign = alu_result[31];

    typedef struct packed {
        logic        own;
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        s;
    } exp_t;

    function automatic exp_t expect_of(input logic own, input logic [31:0] a, input logic [31:0] b,
                                       input logic [4:0] op);
        exp_t        e;
        logic [32:0] sum;
        sum   = {1'b0, a} + {1'b0, b};
        e.own = own;
        e.c   = 1'b0;
        case (op)
            OP_ADD:  begin e.res = sum[31:0]; e.c = sum[32]; end
            OP_AND:  e.res = a & b;
            OP_SHL:  e.res = a << b[4:0];
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        e.s = e.res[31];
        return e;
    endfunction

    exp_t        exp_q[$];
    logic        grant_log[$];
    logic [31:0] res_log[$];
    exp_t        last_rsp;
    int          n_pass = 0;
    int          n_total = 0;
    int          acc0_cnt = 0;
    int          acc1_cnt = 0;
    int          rsp_cnt = 0;
    int          negcnt = 0;
    int          hs_neg = 0;
    int          rv_neg = 0;
    int          rsp1_cycles = 0;
    logic        rv_prev = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        negcnt++;
        if (req0_valid && req0_ready) begin
            exp_q.push_back(expect_of(1'b0, req0_a, req0_b, req0_op));
            grant_log.push_back(1'b0);
            acc0_cnt++;
            hs_neg = negcnt;
        end
        if (req1_valid && req1_ready) begin
            exp_q.push_back(expect_of(1'b1, req1_a, req1_b, req1_op));
            grant_log.push_back(1'b1);
            acc1_cnt++;
            hs_neg = negcnt;
        end
        if ((rsp0_valid === 1'b1 || rsp1_valid === 1'b1) && rv_prev !== 1'b1) rv_neg = negcnt;
        rv_prev = (rsp0_valid === 1'b1) || (rsp1_valid === 1'b1);
        if (rsp1_valid === 1'b1) rsp1_cycles++;
        if ((rsp0_valid === 1'b1 && rsp0_ready) || (rsp1_valid === 1'b1 && rsp1_ready)) begin
            got = {rsp1_valid, rsp_result, rsp_carry, rsp_zero, rsp_sign};
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_unexpected_rsp got=%h required=none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) $display("FAIL scoreboard_rsp got=%h required=%h", got, e);
                else n_pass++;
            end
            last_rsp = got;
            res_log.push_back(rsp_result);
            rsp_cnt++;
        end
    end

    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic sel, input logic [4:0] op);
        int start;
        start = acc0_cnt;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel; req0_op = op;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (acc0_cnt != start) break;
        end
        if (acc0_cnt == start) begin
            n_total++;
            $display("FAIL req0_accept_timeout got=no_accept required=accept");
        end
        req0_valid = 1'b0;
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic sel, input logic [4:0] op);
        int start;
        start = acc1_cnt;
        @(posedge clk); #1;
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel; req1_op = op;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (acc1_cnt != start) break;
        end
        if (acc1_cnt == start) begin
            n_total++;
            $display("FAIL req1_accept_timeout got=no_accept required=accept");
        end
        req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 100; k++) begin
            if (rsp_cnt >= target) break;
            @(posedge clk); #1;
        end
        if (rsp_cnt < target) begin
            n_total++;
            $display("FAIL rsp_timeout got=%0d required=%0d", rsp_cnt, target);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        grant_log.delete();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_sel = 1'b1; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 32'h33; req1_b = 32'h44; req1_sel = 1'b1; req1_op = OP_AND;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_req_ready got=%b required=00", {req0_ready, req1_ready});
        else n_pass++;
        n_total++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00) $display("FAIL reset_rsp_valid got=%b required=00", {rsp0_valid, rsp1_valid});
        else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_sel, alu_op} !== 70'd0) $display("FAIL reset_alu_regs got=%h required=0", {alu_a, alu_b, alu_sel, alu_op});
        else n_pass++;
        n_total++;
        if ({rsp_result, rsp_carry, rsp_zero, rsp_sign} !== 35'd0) $display("FAIL reset_rsp_regs got=%h required=0", {rsp_result, rsp_carry, rsp_zero, rsp_sign});
        else n_pass++;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_q.delete();
        grant_log.delete();
        rst = 1'b1;
    endtask

    task automatic test_single_add();
        int base, r1;
        base = rsp_cnt;
        r1 = rsp1_cycles;
        send0(32'd5, 32'd7, 1'b0, OP_ADD);
        wait_rsp(base + 1);
        n_total++;
        if (rv_neg - hs_neg !== 2) $display("FAIL single_latency got=%0d required=2", rv_neg - hs_neg);
        else n_pass++;
        n_total++;
        if ({last_rsp.own, last_rsp.res, last_rsp.c, last_rsp.z, last_rsp.s} !== {1'b0, 32'd12, 3'b000})
            $display("FAIL single_result got=%h required=%h", last_rsp, {1'b0, 32'd12, 3'b000});
        else n_pass++;
        n_total++;
        if (rsp1_cycles !== r1) $display("FAIL single_rsp1_quiet got=%0d required=%0d", rsp1_cycles - r1, 0);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int          base;
        logic [5:0]  seq;
        do_reset();
        base = rsp_cnt;
        fork
            begin
                send0(32'd3, 32'd4, 1'b0, OP_ADD);
                send0(32'd100, 32'd1, 1'b0, OP_ADD);
                send0(32'hF0F0, 32'h0FF0, 1'b0, OP_AND);
            end
            begin
                send1(32'd10, 32'd20, 1'b0, OP_ADD);
                send1(32'd8, 32'd3, 1'b0, OP_SHL);
                send1(32'h8000_0000, 32'd5, 1'b0, OP_ADD);
            end
        join
        wait_rsp(base + 6);
        seq = '1;
        for (int i = 0; i < 6 && i < grant_log.size(); i++) seq[5-i] = grant_log[i];
        n_total++;
        if (seq !== 6'b010101) $display("FAIL arb_grant_order got=%b required=010101", seq);
        else n_pass++;
        n_total++;
        if (res_log.size() < base + 2 || res_log[base] !== 32'd7 || res_log[base+1] !== 32'd30)
            $display("FAIL arb_first_pair got=%0d,%0d required=7,30",
                     res_log.size() > base ? res_log[base] : 32'hX,
                     res_log.size() > base + 1 ? res_log[base+1] : 32'hX);
        else n_pass++;
    endtask

    task automatic test_carry();
        int base;
        base = rsp_cnt;
        send1(32'hFFFF_FFFF, 32'd1, 1'b0, OP_ADD);
        wait_rsp(base + 1);
        n_total++;
        if ({last_rsp.own, last_rsp.res, last_rsp.c, last_rsp.z, last_rsp.s} !== {1'b1, 32'd0, 3'b110})
            $display("FAIL carry_add got=%h required=%h", last_rsp, {1'b1, 32'd0, 3'b110});
        else n_pass++;
        send1(32'hFFFF_FFFF, 32'd1, 1'b0, OP_AND);
        wait_rsp(base + 2);
        n_total++;
        if ({last_rsp.res, last_rsp.c} !== {32'd1, 1'b0})
            $display("FAIL carry_and_masked got=%h/%b required=1/0", last_rsp.res, last_rsp.c);
        else n_pass++;
    endtask

    task automatic test_stall();
        int base;
        base = rsp_cnt;
        rsp0_ready = 1'b0;
        send0(32'd100, 32'd23, 1'b0, OP_ADD);
        fork
            send1(32'd8, 32'd9, 1'b0, OP_ADD);
            begin
                for (int k = 0; k < 20; k++) begin
                    if (rsp0_valid === 1'b1) break;
                    @(posedge clk); #1;
                end
                for (int c = 0; c < 4; c++) begin
                    n_total++;
                    if ({rsp0_valid, rsp_result} !== {1'b1, 32'd123})
                        $display("FAIL stall_hold cyc=%0d got=%b/%0d required=1/123", c, rsp0_valid, rsp_result);
                    else n_pass++;
                    n_total++;
                    if ({req0_ready, req1_ready} !== 2'b00)
                        $display("FAIL stall_req_ready cyc=%0d got=%b required=00", c, {req0_ready, req1_ready});
                    else n_pass++;
                    @(posedge clk); #1;
                end
                rsp0_ready = 1'b1;
            end
        join
        wait_rsp(base + 2);
        n_total++;
        if ({last_rsp.own, last_rsp.res} !== {1'b1, 32'd17})
            $display("FAIL stall_followup got=%b/%0d required=1/17", last_rsp.own, last_rsp.res);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int rc, gi;
        send0(32'd2, 32'd3, 1'b0, OP_ADD);
        rc = rsp_cnt;
        rst = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(posedge clk); #1;
        n_total++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000)
            $display("FAIL midrst_hs got=%b required=0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_sel, alu_op, rsp_result, rsp_carry, rsp_zero, rsp_sign} !== 105'd0)
            $display("FAIL midrst_regs got=%h required=0", {alu_a, alu_b, alu_op, rsp_result});
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        exp_q.delete();
        n_total++;
        if (rsp_cnt !== rc) $display("FAIL midrst_no_rsp got=%0d required=%0d", rsp_cnt - rc, 0);
        else n_pass++;
        gi = grant_log.size();
        rst = 1'b1;
        fork
            send1(32'd50, 32'd5, 1'b0, OP_ADD);
            send0(32'd40, 32'd2, 1'b0, OP_ADD);
        join
        wait_rsp(rc + 2);
        n_total++;
        if (grant_log.size() < gi + 2 || grant_log[gi] !== 1'b0 || grant_log[gi+1] !== 1'b1)
            $display("FAIL midrst_grant_order got_size=%0d first=%b required=0_then_1",
                     grant_log.size() - gi, grant_log.size() > gi ? grant_log[gi] : 1'bx);
        else n_pass++;
    endtask

    task automatic test_shift_illegal();
        int          base;
        logic [31:0] sampled;
        base = rsp_cnt;
        send0(32'h13, 32'd4, 1'b1, OP_SHL);
        n_total++;
        if (alu_op !== OP_SHL) $display("FAIL shift_alu_op got=%b required=%b", alu_op, OP_SHL);
        else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_sel} !== {32'h13, 32'd4, 1'b1})
            $display("FAIL shift_alu_operands got=%h/%h/%b required=13/4/1", alu_a, alu_b, alu_sel);
        else n_pass++;
        sampled = alu_result;
        wait_rsp(base + 1);
        n_total++;
        if ({last_rsp.res, last_rsp.c} !== {sampled, 1'b0})
            $display("FAIL shift_rsp got=%h/%b required=%h/0", last_rsp.res, last_rsp.c, sampled);
        else n_pass++;
        n_total++;
        if (last_rsp.res !== 32'h130) $display("FAIL shift_value got=%h required=130", last_rsp.res);
        else n_pass++;
        send1(32'd7, 32'd7, 1'b0, 5'b11111);
        wait_rsp(base + 2);
        n_total++;
        if ({last_rsp.own, last_rsp.res, last_rsp.c, last_rsp.z} !== {1'b1, 32'd0, 2'b01})
            $display("FAIL illegal_op got=%h required=zero_flag_set", last_rsp);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = 1'b0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = 1'b0; req1_op = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_reset();
        test_single_add();
        test_arbitration();
        test_carry();
        test_stall();
        test_reset_mid();
        test_shift_illegal();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
